// File: rtl/amc13_tts_tx.sv
// AMC13 TTS return-link serial transmitter: frames a 4-bit TTS code with sync,
// complement, sequence and odd parity, and shifts it out MSB-first at 40 MHz.
module amc13_tts_tx (
  input  logic       clk_40,
  input  logic       rst_n,
  input  logic       enable,
  input  logic [3:0] tts_state,
  input  logic       bad_code_clr,
  output logic       tts_out,
  output logic       frame_start,
  output logic [3:0] tts_sent,
  output logic       bad_code
);

  localparam int unsigned FRAME_W = 16;
  localparam int unsigned CNT_W   = 4;
  localparam int unsigned SEQ_W   = 3;
  localparam int unsigned CODE_W  = 4;

  localparam logic [CODE_W-1:0] SYNC     = 4'b1101;
  localparam logic [CODE_W-1:0] ERR_CODE = 4'hC;
  localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(FRAME_W - 1);

  typedef enum logic {IDLE, SEND} state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic [FRAME_W-1:0]  shift_q, shift_d;
  logic [SEQ_W-1:0]    seq_q, seq_d;
  logic                tts_out_q, tts_out_d;
  logic                frame_start_q, frame_start_d;
  logic [CODE_W-1:0]   tts_sent_q, tts_sent_d;
  logic                bad_code_q, bad_code_d;

  logic                code_legal_c;
  logic [CODE_W-1:0]   code_c;
  logic [FRAME_W-2:0]  frame_body_c;
  logic [FRAME_W-1:0]  frame_c;
  logic                load_c;

  // Legalise the sampled code and assemble the frame; parity makes the ones-count odd.
  always_comb begin
    code_legal_c = 1'b0;
    case (tts_state)
      4'h0, 4'h1, 4'h2, 4'h4, 4'h8, 4'hC, 4'hF: code_legal_c = 1'b1;
      default:                                  code_legal_c = 1'b0;
    endcase
    code_c       = code_legal_c ? tts_state : ERR_CODE;
    frame_body_c = {SYNC, code_c, ~code_c, seq_q};
    frame_c      = {frame_body_c, ~(^frame_body_c)};
  end

  always_comb begin
    state_d       = state_q;
    bit_cnt_d     = bit_cnt_q;
    shift_d       = shift_q;
    seq_d         = seq_q;
    tts_out_d     = tts_out_q;
    frame_start_d = 1'b0;
    tts_sent_d    = tts_sent_q;
    bad_code_d    = bad_code_q;
    load_c        = 1'b0;

    case (state_q)
      IDLE: begin
        tts_out_d = 1'b0;
        load_c    = enable;
      end
      SEND: begin
        if (bit_cnt_q != '0) begin
          tts_out_d = shift_q[FRAME_W-1];
          shift_d   = {shift_q[FRAME_W-2:0], 1'b0};
          bit_cnt_d = bit_cnt_q - CNT_W'(1);
        end else if (enable) begin
          load_c = 1'b1;
        end else begin
          state_d   = IDLE;
          tts_out_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    // MSB goes straight to the output register; the shifter holds the remaining bits.
    if (load_c) begin
      state_d       = SEND;
      bit_cnt_d     = LAST_BIT;
      tts_out_d     = frame_c[FRAME_W-1];
      shift_d       = {frame_c[FRAME_W-2:0], 1'b0};
      frame_start_d = 1'b1;
      tts_sent_d    = code_c;
      seq_d         = seq_q + SEQ_W'(1);
    end

    // A set from an illegal load takes priority over a same-edge clear.
    if (load_c && !code_legal_c) begin
      bad_code_d = 1'b1;
    end else if (bad_code_clr) begin
      bad_code_d = 1'b0;
    end
  end

  always_ff @(posedge clk_40 or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      bit_cnt_q     <= '0;
      shift_q       <= '0;
      seq_q         <= '0;
      tts_out_q     <= 1'b0;
      frame_start_q <= 1'b0;
      tts_sent_q    <= '0;
      bad_code_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      bit_cnt_q     <= bit_cnt_d;
      shift_q       <= shift_d;
      seq_q         <= seq_d;
      tts_out_q     <= tts_out_d;
      frame_start_q <= frame_start_d;
      tts_sent_q    <= tts_sent_d;
      bad_code_q    <= bad_code_d;
    end
  end

  assign tts_out     = tts_out_q;
  assign frame_start = frame_start_q;
  assign tts_sent    = tts_sent_q;
  assign bad_code    = bad_code_q;

endmodule

// File: tb/tb_amc13_tts_tx.sv
// Directed bench for amc13_tts_tx: frame contents, back-to-back timing, seq wrap,
// illegal-code handling, graceful stop and asynchronous reset.
`timescale 1ns/1ps
module tb_amc13_tts_tx;

  logic       clk_40 = 1'b0;
  logic       rst_n;
  logic       enable;
  logic [3:0] tts_state;
  logic       bad_code_clr;
  logic       tts_out;
  logic       frame_start;
  logic [3:0] tts_sent;
  logic       bad_code;

  int checks = 0;
  int errors = 0;

  amc13_tts_tx dut (
    .clk_40      (clk_40),
    .rst_n       (rst_n),
    .enable      (enable),
    .tts_state   (tts_state),
    .bad_code_clr(bad_code_clr),
    .tts_out     (tts_out),
    .frame_start (frame_start),
    .tts_sent    (tts_sent),
    .bad_code    (bad_code)
  );

  always #12.5 clk_40 = ~clk_40;

  task automatic tick();
    @(posedge clk_40);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference frame: sync, code, ~code, seq, odd parity over all 16 bits.
  function automatic logic [15:0] mk(input logic [3:0] c, input logic [2:0] s);
    logic [14:0] u;
    int n;
    u = {4'b1101, c, ~c, s};
    n = 0;
    for (int i = 0; i < 15; i++) n += int'(u[i]);
    return {u, 1'((n % 2) == 0)};
  endfunction

  // Called right after a load edge; samples 16 bit cycles and ends after the next boundary edge.
  task automatic recv_frame(input logic [15:0] exp_w, input logic [3:0] exp_sent,
                            input logic exp_bad, input string tag,
                            input int chg_at, input logic [3:0] chg_state, input logic chg_en,
                            input int clr_at, output logic [15:0] w);
    w = '0;
    for (int i = 0; i < 16; i++) begin
      w[15-i] = tts_out;
      check({tag, "_fs"}, 16'(frame_start), 16'(i == 0));
      if (i == 0) begin
        check({tag, "_sent"}, 16'(tts_sent), 16'(exp_sent));
        check({tag, "_bad"}, 16'(bad_code), 16'(exp_bad));
      end
      if (i == chg_at) begin
        tts_state = chg_state;
        enable    = chg_en;
      end
      bad_code_clr = (i == clr_at);
      tick();
    end
    bad_code_clr = 1'b0;
    check({tag, "_word"}, w, exp_w);
  endtask

  logic [15:0] w;
  logic [2:0]  seq_m;

  initial begin
    rst_n        = 1'b1;
    enable       = 1'b0;
    tts_state    = 4'h0;
    bad_code_clr = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("rst_tts_out", 16'(tts_out), 16'h0);
    check("rst_fs", 16'(frame_start), 16'h0);
    check("rst_sent", 16'(tts_sent), 16'h0);
    check("rst_bad", 16'(bad_code), 16'h0);
    #20 rst_n = 1'b1;
    tick();
    check("idle_out", 16'(tts_out), 16'h0);

    tts_state = 4'h8;
    enable    = 1'b1;
    tick();
    recv_frame(16'hD870, 4'h8, 1'b0, "f0", 3, 4'h4, 1'b1, -1, w);
    recv_frame(16'hD4B3, 4'h4, 1'b0, "f1", -1, 4'h4, 1'b1, -1, w);
    seq_m = 3'd2;
    for (int k = 2; k <= 8; k++) begin
      recv_frame(mk(4'h4, seq_m), 4'h4, 1'b0, "fseq", (k == 8) ? 2 : -1, 4'h3, 1'b1, -1, w);
      seq_m = seq_m + 3'd1;
    end
    check("f8_seq_wrap", 16'(w[3:1]), 16'h0);
    check("f8_word", w, 16'hD4B0);

    // seq_m is now 1: illegal 0x3 goes out as 0xC.
    recv_frame(16'hDC33, 4'hC, 1'b1, "f9", 2, 4'h8, 1'b1, -1, w);
    check("f9_code", 16'(w[11:4]), 16'h00C3);
    recv_frame(mk(4'h8, 3'd2), 4'h8, 1'b1, "f10", -1, 4'h8, 1'b1, 5, w);
    recv_frame(mk(4'h8, 3'd3), 4'h8, 1'b0, "f11", 2, 4'h5, 1'b1, 15, w);
    recv_frame(mk(4'hC, 3'd4), 4'hC, 1'b1, "f12", 2, 4'h8, 1'b1, -1, w);
    recv_frame(mk(4'h8, 3'd5), 4'h8, 1'b1, "f13", 5, 4'h2, 1'b0, -1, w);
    check("stop_out", 16'(tts_out), 16'h0);
    check("stop_fs", 16'(frame_start), 16'h0);
    tick();
    tick();
    tick();
    check("idle_hold_out", 16'(tts_out), 16'h0);
    check("idle_hold_fs", 16'(frame_start), 16'h0);

    enable = 1'b1;
    tick();
    recv_frame(mk(4'h2, 3'd6), 4'h2, 1'b1, "f14", -1, 4'h2, 1'b1, -1, w);
    check("f14_code", 16'(w[11:4]), 16'h002D);
    check("f14_seq", 16'(w[3:1]), 16'h0006);

    // Frame 15 (code 2, seq 7) is loaded; bit 14 is a one.
    tick();
    check("pre_rst_out", 16'(tts_out), 16'h1);
    #5 rst_n = 1'b0;
    #1;
    check("arst_out", 16'(tts_out), 16'h0);
    check("arst_fs", 16'(frame_start), 16'h0);
    check("arst_sent", 16'(tts_sent), 16'h0);
    check("arst_bad", 16'(bad_code), 16'h0);
    enable = 1'b0;
    #5 rst_n = 1'b1;
    tick();
    check("post_rst_idle", 16'(tts_out), 16'h0);
    tts_state = 4'h8;
    enable    = 1'b1;
    tick();
    recv_frame(16'hD870, 4'h8, 1'b0, "post_rst", 3, 4'h8, 1'b0, -1, w);
    check("final_out", 16'(tts_out), 16'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/amc13_tts_tx.md
# amc13_tts_tx

Serial transmitter for the legacy AMC13 TTS return link, the outbound side of the AMC13 clock/data pair. It samples a 4-bit TTS state once per frame, builds a 16-bit framed word (sync, state, complement, sequence, parity) and shifts it out MSB-first, one bit per 40 MHz clock. It sits in the AMC13 clock domain, and its serial output drives the TTS differential output buffer.

## Interface
- No parameters. Frame length is fixed at 16 bits, the sync nibble is 4'b1101, and the sequence counter is 3 bits.
- clk_40  input  1  extracted 40 MHz experimental clock; all logic is on its rising edge
- rst_n  input  1  asynchronous, active-low reset
- enable  input  1  1 = transmit frames continuously; 0 = finish the current frame, then idle
- tts_state  input  4  requested TTS code; sampled only at frame load
- bad_code_clr  input  1  single-cycle clear of bad_code
- tts_out  output  1  registered serial TTS bit, toward the output buffer
- frame_start  output  1  one-cycle pulse, high in the cycle the frame MSB is on tts_out
- tts_sent  output  4  code carried by the frame currently being shifted
- bad_code  output  1  sticky flag: an illegal tts_state was sampled at some frame load

## Operation
- Legal codes are 0x0, 0x1, 0x2, 0x4, 0x8, 0xC and 0xF.
  - Any other sampled code is transmitted as 0xC (error).
  - In the same cycle, bad_code is set.
- Frame layout, bit 15 first:
  - [15:12] = 4'b1101
  - [11:8] = code
  - [7:4] = ~code
  - [3:1] = seq
  - [0] = parity, chosen so the total number of ones in the 16 bits is odd
- seq counter:
  - Resets to 0; the first frame after reset carries seq = 0.
  - Increments by 1 after each frame load and wraps 7 -> 0.
  - It is not reset by enable going low.
- FSM, two states:
  - IDLE:
    - tts_out = 0.
    - On an edge with enable = 1: load the frame, bit_cnt <= 15, tts_out <= frame[15], frame_start <= 1, tts_sent <= code, go to SEND.
  - SEND:
    - Each edge with bit_cnt > 0: tts_out <= next bit, bit_cnt decrements.
    - At the edge where bit_cnt = 0 (last bit has been on tts_out for one cycle):
      - enable = 1: load the next frame back-to-back, with no gap cycle, and stay in SEND.
      - enable = 0: go to IDLE, tts_out <= 0.
- enable falling mid-frame never truncates a frame. enable is sampled only in IDLE and at the bit_cnt = 0 edge.
- tts_state changes mid-frame have no effect until the next load.
- bad_code_clr:
  - Clears bad_code on the next edge.
  - If a set (illegal code loaded) and a clear occur on the same edge, the set wins.
- Reset (asynchronous, can occur at any point, including mid-frame):
  - State goes to IDLE; the partial frame is abandoned.
  - tts_out = 0, frame_start = 0, tts_sent = 0x0, bad_code = 0, seq = 0, bit_cnt = 0, shift register = 0.

## Timing
- Frame period is 16 clk_40 cycles (400 ns). Each bit is held for exactly one cycle.
- Start latency: enable high at edge N (in IDLE) -> frame MSB on tts_out and frame_start = 1 in the cycle after edge N.
- Back-to-back frames: the frame_start pulses are exactly 16 cycles apart.
- Stop latency: if enable is low at the bit_cnt = 0 edge, tts_out = 0 from that edge on. The last frame is always complete.
- tts_sent and bad_code update on the same edge as frame_start.
- Release of reset is synchronized by the parent. The block itself requires only one full clk_40 cycle after rst_n rises before enable is honored.

## Test plan
- Reset, then enable = 1 with tts_state = 0x8:
  - First frame is 0xD870 (seq 0, parity 0), MSB first.
  - frame_start = 1 in the first bit cycle, tts_sent = 0x8.
  - The next frame_start comes 16 cycles later.
- Hold tts_state = 0x4 for the second frame -> 0xD4B3 (seq 1, parity 1). Run 9 frames total and check that seq wraps 7 -> 0 on frame 9.
- tts_state = 0x3 at a load:
  - Transmitted code is 0xC, so frame [11:4] = 0xC3.
  - bad_code = 1 and stays set.
  - Pulsing bad_code_clr clears it.
  - Pulsing bad_code_clr on the same edge as another illegal load leaves bad_code = 1.
- Drop enable at bit 5 of a frame:
  - The remaining bits complete unaltered.
  - tts_out = 0 after the last bit and the FSM returns to IDLE.
  - Raising enable again starts a frame with the next seq value, not 0.
- Change tts_state from 0x8 to 0x2 mid-frame -> the current frame still carries 0x8, and the next frame carries 0x2 (frame [11:4] = 0x2D).
- Assert rst_n = 0 asynchronously mid-frame:
  - All outputs go to their reset values immediately, without waiting for a clock edge.
  - After release, the first frame carries seq = 0.
